// File: rtl/mips_run_controller.sv
// rtl/mips_run_controller.sv - session sequencer for single_cycle_mips.
// Flow: load imem from a word stream, run for a bounded budget or until halt, then stream out the register file.
module mips_run_controller #(
  parameter int ADDR_W     = 8,
  parameter int DATA_W     = 32,
  parameter int RUN_CYCLES = 51
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              start,
  input  logic [ADDR_W:0]   prog_len,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [DATA_W-1:0] imem_wdata,
  output logic              cpu_rst_n,
  output logic              cpu_run,
  input  logic              cpu_halt,
  output logic [4:0]        rf_raddr,
  input  logic [DATA_W-1:0] rf_rdata,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              busy,
  output logic              done,
  output logic [15:0]       cycles_run
);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_RUN, S_DUMP, S_DONE} state_t;

  localparam logic [15:0]   RUN_LIMIT = 16'(RUN_CYCLES);
  localparam logic [15:0]   CYC_MAX   = 16'hFFFF;
  localparam logic [15:0]   CYC_ONE   = 16'd1;
  localparam logic [ADDR_W:0] LEN_ONE = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [ADDR_W:0] LEN_ZERO = '0;
  localparam logic [4:0]    DUMP_LAST = 5'd31;
  localparam logic [4:0]    DUMP_ONE  = 5'd1;

  state_t            state_q, state_d;
  logic [ADDR_W:0]   len_q, len_d;
  logic [ADDR_W:0]   load_ptr_q, load_ptr_d;
  logic [4:0]        dump_ptr_q, dump_ptr_d;
  logic [15:0]       cycles_q, cycles_d;

  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    load_ptr_d = load_ptr_q;
    dump_ptr_d = dump_ptr_q;
    cycles_d   = cycles_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          len_d      = prog_len;
          load_ptr_d = '0;
          dump_ptr_d = '0;
          cycles_d   = '0;
          state_d    = (prog_len == LEN_ZERO) ? S_RUN : S_LOAD;
        end
      end
      S_LOAD: begin
        if (in_valid) begin
          load_ptr_d = load_ptr_q + LEN_ONE;
          if (load_ptr_q == len_q - LEN_ONE) state_d = S_RUN;
        end
      end
      S_RUN: begin
        if (cycles_q != CYC_MAX) cycles_d = cycles_q + CYC_ONE;
        // The halting cycle is already counted in cycles_d, so both exits agree.
        if (cycles_d == RUN_LIMIT || cpu_halt) state_d = S_DUMP;
      end
      S_DUMP: begin
        if (out_ready) begin
          dump_ptr_d = dump_ptr_q + DUMP_ONE;
          if (dump_ptr_q == DUMP_LAST) state_d = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      len_q      <= '0;
      load_ptr_q <= '0;
      dump_ptr_q <= '0;
      cycles_q   <= '0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      load_ptr_q <= load_ptr_d;
      dump_ptr_q <= dump_ptr_d;
      cycles_q   <= cycles_d;
    end
  end

  // Outputs decode only the state register, so an async reset clears them at once.
  assign in_ready   = (state_q == S_LOAD);
  assign imem_we    = in_ready && in_valid;
  assign imem_addr  = in_ready ? load_ptr_q[ADDR_W-1:0] : '0;
  assign imem_wdata = in_ready ? in_data : '0;
  assign cpu_run    = (state_q == S_RUN);
  assign cpu_rst_n  = (state_q == S_RUN) || (state_q == S_DUMP) || (state_q == S_DONE);
  assign out_valid  = (state_q == S_DUMP);
  assign rf_raddr   = out_valid ? dump_ptr_q : '0;
  assign out_data   = out_valid ? rf_rdata : '0;
  assign busy       = in_ready || cpu_run || out_valid;
  assign done       = (state_q == S_DONE);
  assign cycles_run = cycles_q;

endmodule

// File: tb/tb_mips_run_controller.sv
// tb/tb_mips_run_controller.sv - directed self-checking bench for mips_run_controller.
module tb_mips_run_controller;
  localparam int ADDR_W = 8;
  localparam int DATA_W = 32;
  localparam int RUN_CYCLES = 5;

  logic              clock = 1'b0;
  logic              reset_n = 1'b0;
  logic              start = 1'b0;
  logic [ADDR_W:0]   prog_len = '0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [DATA_W-1:0] in_data = '0;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [DATA_W-1:0] imem_wdata;
  logic              cpu_rst_n;
  logic              cpu_run;
  logic              cpu_halt = 1'b0;
  logic [4:0]        rf_raddr;
  logic [DATA_W-1:0] rf_rdata;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [DATA_W-1:0] out_data;
  logic              busy;
  logic              done;
  logic [15:0]       cycles_run;

  int errors = 0;
  int checks = 0;

  mips_run_controller #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RUN_CYCLES(RUN_CYCLES)) dut (
    .clock(clock), .reset_n(reset_n), .start(start), .prog_len(prog_len),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .cpu_rst_n(cpu_rst_n), .cpu_run(cpu_run), .cpu_halt(cpu_halt),
    .rf_raddr(rf_raddr), .rf_rdata(rf_rdata),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .busy(busy), .done(done), .cycles_run(cycles_run)
  );

  always #5 clock = ~clock;

  // Register-file stand-in: register k holds C0DE_00kk.
  assign rf_rdata = 32'hC0DE_0000 | {27'd0, rf_raddr};

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clock);
    #2;
  endtask

  task automatic drain(input bit toggle, input logic [15:0] exp_cycles);
    logic [DATA_W-1:0] got[$];
    logic [DATA_W-1:0] held;
    bit stalled;
    stalled = 1'b0;
    held = '0;
    for (int i = 0; i < 200 && !done; i++) begin
      out_ready = toggle ? ((i % 4 == 0) || (i % 4 == 3)) : 1'b1;
      #1;
      if (stalled) chk("dump_hold", out_data, held);
      stalled = out_valid && !out_ready;
      held = out_data;
      if (out_valid && out_ready) got.push_back(out_data);
      tick();
    end
    out_ready = 1'b0;
    #1;
    chk("dump_count", got.size(), 32);
    for (int k = 0; k < got.size() && k < 32; k++)
      chk($sformatf("dump_word%0d", k), got[k], 32'hC0DE_0000 + k);
    chk("done_high", done, 1'b1);
    chk("done_busy", busy, 1'b0);
    chk("done_out_valid", out_valid, 1'b0);
    chk("done_cpu_run", cpu_run, 1'b0);
    chk("done_cycles", cycles_run, exp_cycles);
  endtask

  initial begin
    int runcnt;
    // Reset state, with in_valid asserted to show it is ignored.
    in_valid = 1'b1;
    #3;
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_cpu_rst_n", cpu_rst_n, 1'b0);
    chk("rst_cpu_run", cpu_run, 1'b0);
    chk("rst_imem_we", imem_we, 1'b0);
    chk("rst_in_ready", in_ready, 1'b0);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_cycles", cycles_run, 16'd0);
    in_valid = 1'b0;
    #9 reset_n = 1'b1;

    // Test 1: load three words back to back.
    tick();
    start = 1'b1; prog_len = 9'd3;
    tick();
    start = 1'b0;
    #1;
    chk("load_busy", busy, 1'b1);
    chk("load_in_ready", in_ready, 1'b1);
    chk("load_cpu_rst_n", cpu_rst_n, 1'b0);
    chk("load_imem_we_idle", imem_we, 1'b0);
    in_valid = 1'b1; in_data = 32'hAAAA_0001;
    #1;
    chk("load_we0", imem_we, 1'b1);
    chk("load_addr0", imem_addr, 8'd0);
    chk("load_data0", imem_wdata, 32'hAAAA_0001);
    tick();
    in_data = 32'hBBBB_0002;
    #1;
    chk("load_addr1", imem_addr, 8'd1);
    chk("load_data1", imem_wdata, 32'hBBBB_0002);
    tick();
    in_data = 32'hCCCC_0003;
    #1;
    chk("load_addr2", imem_addr, 8'd2);
    chk("load_data2", imem_wdata, 32'hCCCC_0003);
    chk("load_still", cpu_run, 1'b0);
    tick();
    #1;
    chk("run_entered", cpu_run, 1'b1);
    chk("run_cpu_rst_n", cpu_rst_n, 1'b1);
    chk("run_no_we", imem_we, 1'b0);
    chk("run_cycles0", cycles_run, 16'd0);
    in_valid = 1'b0;

    // Test 2: full budget with no halt.
    runcnt = 0;
    for (int i = 0; i < 20 && cpu_run; i++) begin
      runcnt++;
      tick();
    end
    chk("budget_run_len", runcnt, 5);
    chk("budget_cycles", cycles_run, 16'd5);
    chk("budget_dump", out_valid, 1'b1);
    chk("budget_cpu_rst_n", cpu_rst_n, 1'b1);

    // Test 4: dump with out_ready 1,0,0,1 pattern.
    drain(1'b1, 16'd5);

    // Test 5: zero-length program goes straight to RUN; in_valid ignored.
    start = 1'b1; prog_len = 9'd0; in_valid = 1'b1;
    tick();
    start = 1'b0;
    #1;
    chk("zlen_run", cpu_run, 1'b1);
    chk("zlen_no_we", imem_we, 1'b0);
    chk("zlen_done_drop", done, 1'b0);
    chk("zlen_cycles_clr", cycles_run, 16'd0);
    in_valid = 1'b0;

    // Test 3: halt on the third RUN cycle; start mid-session ignored.
    tick();
    tick();
    cpu_halt = 1'b1; start = 1'b1;
    tick();
    cpu_halt = 1'b0; start = 1'b0;
    #1;
    chk("halt_dump", out_valid, 1'b1);
    chk("halt_cpu_run", cpu_run, 1'b0);
    chk("halt_cycles", cycles_run, 16'd3);
    chk("halt_busy", busy, 1'b1);

    // Test 6a: reset mid-DUMP.
    out_ready = 1'b1;
    tick();
    tick();
    out_ready = 1'b0;
    reset_n = 1'b0;
    #1;
    chk("rstd_out_valid", out_valid, 1'b0);
    chk("rstd_busy", busy, 1'b0);
    chk("rstd_cpu_rst_n", cpu_rst_n, 1'b0);
    chk("rstd_cycles", cycles_run, 16'd0);
    reset_n = 1'b1;

    // Test 6b: reset mid-LOAD while a word is offered.
    tick();
    start = 1'b1; prog_len = 9'd2;
    tick();
    start = 1'b0; in_valid = 1'b1; in_data = 32'h1234_5678;
    #1;
    chk("rstl_we_before", imem_we, 1'b1);
    reset_n = 1'b0;
    #1;
    chk("rstl_we", imem_we, 1'b0);
    chk("rstl_in_ready", in_ready, 1'b0);
    chk("rstl_busy", busy, 1'b0);
    in_valid = 1'b0;
    reset_n = 1'b1;

    // Fresh session after the aborts completes cleanly.
    tick();
    start = 1'b1; prog_len = 9'd1;
    tick();
    start = 1'b0; in_valid = 1'b1; in_data = 32'hFEED_BEEF;
    #1;
    chk("fresh_we", imem_we, 1'b1);
    chk("fresh_addr", imem_addr, 8'd0);
    tick();
    in_valid = 1'b0;
    runcnt = 0;
    for (int i = 0; i < 20 && cpu_run; i++) begin
      runcnt++;
      tick();
    end
    chk("fresh_run_len", runcnt, 5);
    drain(1'b0, 16'd5);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
